// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the user LED bank. A requester holds the bank for at
// most HOLD_CYCLES cycles. The bank then stays dark for GAP_CYCLES cycles,
// with at least one IDLE cycle, before the next owner is chosen. LEDs are
// active-low, so all-ones means dark.
module led_bank_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LED_W       = 6,
  parameter int HOLD_CYCLES = 13_500_000,
  parameter int GAP_CYCLES  = 270_000,
  parameter int CNT_W       = 25
) (
  input  logic                       bank1_3v3_xtal_in,
  input  logic                       bank3_1v8_sys_rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LED_W-1:0]   pattern,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic                       expired,
  output logic [LED_W-1:0]           bank3_1v8_led
);

  localparam int OWNER_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [LED_W-1:0] LED_DARK  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [OWNER_W-1:0]   last_owner, last_owner_nx;
  logic [NUM_REQ-1:0]   grant_nx;
  logic [OWNER_W-1:0]   owner_nx;
  logic                 busy_nx;
  logic                 expired_nx;
  logic [LED_W-1:0]     led_nx;

  logic                 win_found;
  logic [OWNER_W-1:0]   win_idx;
  logic [OWNER_W-1:0]   scan_idx;
  logic [LED_W-1:0]     pat_arr [NUM_REQ];

  // Split the flat pattern bus into one entry per source.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pat
    assign pat_arr[g] = pattern[g*LED_W +: LED_W];
  end

  // Round-robin pick: the first active request after the last owner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_idx = OWNER_W'((int'(last_owner) + i) % NUM_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/HOLD/GAP cycle.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    last_owner_nx = last_owner;
    grant_nx      = grant;
    owner_nx      = owner;
    busy_nx       = busy;
    expired_nx    = 1'b0;
    led_nx        = bank3_1v8_led;

    unique case (state)
      IDLE: begin
        led_nx   = LED_DARK;
        grant_nx = '0;
        busy_nx  = 1'b0;
        if (win_found) begin
          grant_nx = NUM_REQ'(1) << win_idx;
          owner_nx = win_idx;
          busy_nx  = 1'b1;
          led_nx   = pat_arr[win_idx];
          cnt_nx   = '0;
          state_nx = HOLD;
        end
      end

      HOLD: begin
        led_nx = pat_arr[owner];
        if (!req[owner] || cnt == HOLD_LAST) begin
          // A dropped request wins over a simultaneous terminal count.
          expired_nx    = req[owner];
          grant_nx      = '0;
          led_nx        = LED_DARK;
          last_owner_nx = owner;
          cnt_nx        = '0;
          state_nx      = GAP;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      GAP: begin
        led_nx   = LED_DARK;
        grant_nx = '0;
        busy_nx  = 1'b1;
        if (cnt == GAP_LAST) begin
          cnt_nx   = '0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        busy_nx  = 1'b0;
        led_nx   = LED_DARK;
        cnt_nx   = '0;
      end
    endcase
  end

  // State and output registers. After reset, source 0 has top priority.
  always_ff @(posedge bank1_3v3_xtal_in or posedge bank3_1v8_sys_rst) begin
    if (bank3_1v8_sys_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last_owner    <= OWNER_W'(NUM_REQ - 1);
      grant         <= '0;
      owner         <= '0;
      busy          <= 1'b0;
      expired       <= 1'b0;
      bank3_1v8_led <= LED_DARK;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      last_owner    <= last_owner_nx;
      grant         <= grant_nx;
      owner         <= owner_nx;
      busy          <= busy_nx;
      expired       <= expired_nx;
      bank3_1v8_led <= led_nx;
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter (HOLD=4, GAP=2, four sources).
// Directed scenarios push one expected grant record per ownership period.
// A negedge monitor pops a record on every grant rise. It checks the grant,
// the owner and the first LED value, the dark gap before the grant, the hold
// length and the expired flag.
module tb_led_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] pattern;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic        expired;
  logic [5:0]  led;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic [5:0] led;
    int         len;
    logic       expired;
    int         gap;
  } grant_exp_t;

  grant_exp_t exp_q[$];

  led_bank_arbiter #(
    .NUM_REQ(4), .LED_W(6), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(3)
  ) dut (
    .bank1_3v3_xtal_in(clk),
    .bank3_1v8_sys_rst(rst),
    .req(req),
    .pattern(pattern),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .expired(expired),
    .bank3_1v8_led(led)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input int cycles);
    req = r;
    tick(cycles);
  endtask

  task automatic setPattern(input int src, input logic [5:0] val);
    pattern[src*6 +: 6] = val;
  endtask

  task automatic pushExp(input logic [3:0] g, input logic [1:0] o, input logic [5:0] l,
                         input int len, input logic e, input int gap);
    grant_exp_t x;
    x.grant = g; x.owner = o; x.led = l; x.len = len; x.expired = e; x.gap = gap;
    exp_q.push_back(x);
  endtask

  // Monitor: tracks grant periods and dark gaps and compares them against the scoreboard.
  logic [3:0] prev_grant = '0;
  logic       prev_exp   = 1'b0;
  int         hold_cnt   = 0;
  int         zero_cnt   = 0;
  bit         active     = 1'b0;
  grant_exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      active     = 1'b0;
      prev_grant = '0;
      prev_exp   = 1'b0;
      hold_cnt   = 0;
      zero_cnt   = 0;
    end else begin
      if (prev_exp) checkOutput("expired_width", {31'd0, expired}, 32'd0);
      if (grant != 4'b0 && prev_grant == 4'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_grant: got %b expected none", grant);
          active = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          checkOutput("grant", {28'd0, grant}, {28'd0, cur.grant});
          checkOutput("owner", {30'd0, owner}, {30'd0, cur.owner});
          checkOutput("grant_led", {26'd0, led}, {26'd0, cur.led});
          if (cur.gap >= 0) checkOutput("gap_len", zero_cnt, cur.gap);
        end
        hold_cnt = 1;
      end else if (grant != 4'b0) begin
        hold_cnt++;
        if (grant != prev_grant) begin
          checks++;
          errors++;
          $display("[TB] FAIL grant_stable: got %b expected %b", grant, prev_grant);
        end
        if (expired && !prev_exp) checkOutput("expired_stray", {31'd0, expired}, 32'd0);
      end else if (prev_grant != 4'b0) begin
        if (active) begin
          checkOutput("hold_len", hold_cnt, cur.len);
          checkOutput("expired", {31'd0, expired}, {31'd0, cur.expired});
          checkOutput("gap_busy", {31'd0, busy}, 32'd1);
          checkOutput("gap_led", {26'd0, led}, 32'h3F);
        end
        active   = 1'b0;
        zero_cnt = 1;
      end else begin
        zero_cnt++;
        if (expired && !prev_exp) checkOutput("expired_stray", {31'd0, expired}, 32'd0);
      end
      prev_grant = grant;
      prev_exp   = expired;
    end
  end

  // Watchdog: stops a run that goes on far past the directed scenarios.
  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst = 1'b1;
    req = 4'b0;
    pattern = '1;
    setPattern(0, 6'h3E);
    setPattern(1, 6'h15);
    setPattern(2, 6'h2A);
    setPattern(3, 6'h07);
    tick(2);
    checkOutput("reset_grant", {28'd0, grant}, 32'd0);
    checkOutput("reset_led", {26'd0, led}, 32'h3F);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_owner", {30'd0, owner}, 32'd0);
    checkOutput("reset_expired", {31'd0, expired}, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("[TB] round robin");
    pushExp(4'b0001, 2'd0, 6'h3E, 4, 1'b1, -1);
    pushExp(4'b0010, 2'd1, 6'h15, 4, 1'b1, 3);
    pushExp(4'b1000, 2'd3, 6'h07, 4, 1'b1, 3);
    pushExp(4'b0001, 2'd0, 6'h3E, 4, 1'b1, 3);
    applyStimulus(4'b1011, 1);
    tick(25);
    applyStimulus(4'b0000, 6);

    $display("[TB] reset mid-hold");
    pushExp(4'b0001, 2'd0, 6'h3E, 4, 1'b1, -1);
    applyStimulus(4'b0001, 1);
    tick(2);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_grant", {28'd0, grant}, 32'd0);
    checkOutput("rst_mid_led", {26'd0, led}, 32'h3F);
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_expired", {31'd0, expired}, 32'd0);
    pushExp(4'b0001, 2'd0, 6'h3E, 4, 1'b1, -1);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("post_rst_grant", {28'd0, grant}, 32'b0001);
    tick(4);
    applyStimulus(4'b0000, 6);

    $display("[TB] timeout");
    pushExp(4'b0100, 2'd2, 6'h2A, 4, 1'b1, -1);
    pushExp(4'b0100, 2'd2, 6'h2A, 4, 1'b1, 3);
    applyStimulus(4'b0100, 1);
    tick(11);
    applyStimulus(4'b0000, 6);

    $display("[TB] early release");
    pushExp(4'b0010, 2'd1, 6'h15, 3, 1'b0, -1);
    pushExp(4'b0010, 2'd1, 6'h15, 4, 1'b1, 3);
    applyStimulus(4'b0010, 1);
    tick(2);
    applyStimulus(4'b0000, 1);
    checkOutput("early_grant", {28'd0, grant}, 32'd0);
    checkOutput("early_expired", {31'd0, expired}, 32'd0);
    applyStimulus(4'b0010, 7);
    applyStimulus(4'b0000, 6);

    $display("[TB] tie release and terminal count");
    pushExp(4'b1000, 2'd3, 6'h07, 4, 1'b0, -1);
    applyStimulus(4'b1000, 1);
    tick(3);
    applyStimulus(4'b0000, 1);
    checkOutput("tie_busy", {31'd0, busy}, 32'd1);
    checkOutput("tie_grant", {28'd0, grant}, 32'd0);
    checkOutput("tie_expired", {31'd0, expired}, 32'd0);
    checkOutput("tie_led", {26'd0, led}, 32'h3F);
    tick(6);

    $display("[TB] live pattern");
    pushExp(4'b0001, 2'd0, 6'h3E, 3, 1'b0, -1);
    applyStimulus(4'b0001, 1);
    tick(1);
    checkOutput("live_led_old", {26'd0, led}, 32'h3E);
    setPattern(0, 6'h3D);
    tick(1);
    checkOutput("live_led_new", {26'd0, led}, 32'h3D);
    applyStimulus(4'b0000, 8);

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
